// File: rtl/apmu_ibex_pmu_counter_bank.sv
// Performance-counter bank with a three-state request handshake (read/write, wait-for-positive, wait-for-overflow).
// Optional macro APMU_PMC_WAIT_TIMEOUT_EN bounds wait operations to TIMEOUT_CYCLES cycles.

package ibex_pkg;
    typedef enum logic [1:0] {
        PMC_IDLE = 2'd0,
        PMC_REQ  = 2'd1,
        PMC_WFP  = 2'd2,
        PMC_WFO  = 2'd3
    } pmc_op_e;
endpackage

module apmu_ibex_pmu_counter_bank #(
    parameter int NUM_COUNTERS   = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  ibex_pkg::pmc_op_e       counter_op_i,
    output logic                    counter_gnt_o,
    output logic                    counter_rvalid_o,
    output logic                    counter_err_o,
    input  logic [31:0]             counter_addr_i,
    input  logic                    counter_we_i,
    input  logic [31:0]             counter_wdata_i,
    output logic [31:0]             counter_rdata_o,
    input  logic [NUM_COUNTERS-1:0] event_i,
    output logic [NUM_COUNTERS-1:0] ovf_o
);
    import ibex_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RESP = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam logic [4:0] NUM_CNT = 5'(NUM_COUNTERS);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    pmc_op_e     op_q, op_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_data_q, resp_data_d;

    logic [NUM_COUNTERS*32-1:0] cnt_flat;
    logic [NUM_COUNTERS-1:0]    wr_en;
    logic [NUM_COUNTERS-1:0]    ovf_clr;

    logic [3:0]  addr_idx;
    logic        addr_ok;
    logic        accept;
    logic [31:0] addr_val;
    logic [31:0] wait_val;
    logic        wait_ovf;
    logic        wait_hit;
    logic        timeout_hit;
    logic        wait_abort;
    logic        wait_fire;
    logic        wait_tmo;

    assign addr_idx = counter_addr_i[5:2];
    assign addr_ok  = (counter_addr_i[1:0] == 2'b00) &&
                      (counter_addr_i[31:6] == 26'd0) &&
                      ({1'b0, addr_idx} < NUM_CNT);
    assign accept   = (state_q == S_IDLE) && (counter_op_i != PMC_IDLE);

    // Two independent read ports: one for the address being accepted, one for the counter being waited on.
    always_comb begin
        addr_val = '0;
        wait_val = '0;
        wait_ovf = 1'b0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (addr_idx == 4'(i)) begin
                addr_val = cnt_flat[i*32 +: 32];
            end
            if (idx_q == 4'(i)) begin
                wait_val = cnt_flat[i*32 +: 32];
                wait_ovf = ovf_o[i];
            end
        end
    end

    assign wait_hit = (op_q == PMC_WFO) ? wait_ovf
                                        : (!wait_val[31] && (wait_val != 32'd0));

`ifdef APMU_PMC_WAIT_TIMEOUT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = '0;
        if (state_q == S_WAIT) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th cycle spent in S_WAIT.
    assign timeout_hit = (state_q == S_WAIT) && (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    // State and request-context registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            op_q        <= PMC_IDLE;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            resp_err_q  <= resp_err_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_d        = op_q;
        resp_err_d  = resp_err_q;
        resp_data_d = resp_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    idx_d = addr_idx;
                    op_d  = counter_op_i;
                    if (!addr_ok) begin
                        state_d     = S_RESP;
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                    end else if (counter_op_i == PMC_REQ) begin
                        // Read data is the value before any write landing on this edge.
                        state_d     = S_RESP;
                        resp_err_d  = 1'b0;
                        resp_data_d = addr_val;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            S_WAIT: begin
                if (wait_abort || wait_fire || wait_tmo) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic; a dropped op wins over a same-cycle completion.
    always_comb begin
        wait_abort       = (state_q == S_WAIT) && (counter_op_i == PMC_IDLE);
        wait_fire        = (state_q == S_WAIT) && !wait_abort && wait_hit;
        wait_tmo         = (state_q == S_WAIT) && !wait_abort && !wait_hit && timeout_hit;
        counter_gnt_o    = (state_q == S_IDLE);
        counter_rvalid_o = (state_q == S_RESP) || wait_fire || wait_tmo;
        counter_err_o    = ((state_q == S_RESP) && resp_err_q) || wait_tmo;
        counter_rdata_o  = '0;
        if (state_q == S_RESP) begin
            counter_rdata_o = resp_data_q;
        end else if (wait_fire || wait_tmo) begin
            counter_rdata_o = wait_val;
        end
    end

    for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_cnt
        logic [31:0] cnt_q, cnt_d;
        logic        ovf_q, ovf_d;

        assign wr_en[gi]   = accept && addr_ok && (counter_op_i == PMC_REQ) &&
                             counter_we_i && (addr_idx == 4'(gi));
        assign ovf_clr[gi] = wait_fire && (op_q == PMC_WFO) && (idx_q == 4'(gi));

        // A write overrides a same-cycle event; a wrap re-arms the flag even on a clearing edge.
        always_comb begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
            if (wr_en[gi]) begin
                cnt_d = counter_wdata_i;
                ovf_d = 1'b0;
            end else begin
                if (ovf_clr[gi]) begin
                    ovf_d = 1'b0;
                end
                if (event_i[gi]) begin
                    cnt_d = cnt_q + 32'd1;
                    if (&cnt_q) begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end
        end

        assign cnt_flat[gi*32 +: 32] = cnt_q;
        assign ovf_o[gi]             = ovf_q;
    end

endmodule

// File: doc/apmu_ibex_pmu_counter_bank.md
APMU_IBEX_PMU_COUNTER_BANK -- requirements
Module: apmu_ibex_pmu_counter_bank

Interface
REQ-001 SHALL have parameter NUM_COUNTERS, default 8, number of 32-bit event counters (1..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, wait-op timeout limit (used only under REQ-031).
REQ-003 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port counter_op_i  input  ibex_pkg::pmc_op_e  operation from core (PMC_IDLE/PMC_REQ/PMC_WFP/PMC_WFO).
REQ-006 SHALL have port counter_gnt_o  output  1  bank ready to accept an op.
REQ-007 SHALL have port counter_rvalid_o  output  1  one-cycle response strobe.
REQ-008 SHALL have port counter_err_o  output  1  error qualifier, valid with rvalid.
REQ-009 SHALL have port counter_addr_i  input  32  byte address; bits [5:2] select counter.
REQ-010 SHALL have port counter_we_i  input  1  write enable for PMC_REQ.
REQ-011 SHALL have port counter_wdata_i  input  32  write data.
REQ-012 SHALL have port counter_rdata_o  output  32  response data, valid with rvalid.
REQ-013 SHALL have port event_i  input  NUM_COUNTERS  per-counter increment strobes.
REQ-014 SHALL have port ovf_o  output  NUM_COUNTERS  sticky per-counter overflow flags.

Function
REQ-015 SHALL implement FSM states S_IDLE, S_RESP, S_WAIT; counter_gnt_o = 1 only in S_IDLE.
REQ-016 S_IDLE, op != PMC_IDLE: SHALL accept op and latch index, we, wdata, op.
REQ-017 Address invalid (addr[1:0] != 0, index >= NUM_COUNTERS, or addr[31:6] != 0): SHALL go S_RESP with err=1, rdata=0, no state change.
REQ-018 PMC_REQ read: next cycle (S_RESP) rvalid=1, rdata = counter value at accept cycle; latency exactly 1.
REQ-019 PMC_REQ write: counter <= wdata at accept edge, its ovf flag cleared; S_RESP rdata = pre-write value.
REQ-020 S_RESP SHALL last one cycle, then return to S_IDLE.
REQ-021 PMC_WFP/PMC_WFO: SHALL enter S_WAIT; rvalid held 0 until completion.
REQ-022 WFP completes in first S_WAIT cycle where registered counter is signed > 0 (bit31=0, nonzero).
REQ-023 WFO completes in first S_WAIT cycle where that counter's ovf flag = 1; completion clears the flag.
REQ-024 On completion: rvalid=1, err=0, rdata = registered counter value that cycle, next state S_IDLE.
REQ-025 In S_WAIT, counter_op_i == PMC_IDLE SHALL abort: return to S_IDLE, no rvalid.
REQ-026 Counter i SHALL increment by 1 each cycle event_i[i]=1; 0xFFFFFFFF wraps to 0 and sets ovf flag i.
REQ-027 Write and event on same counter same cycle: write wins, event dropped, ovf cleared.
REQ-028 rvalid and err SHALL be 0 outside response cycles; rdata SHALL be 0 when rvalid=0.

Reset
REQ-029 rst_ni low SHALL asynchronously force S_IDLE, all counters 0, ovf_o 0, rvalid 0, err 0, rdata 0.
REQ-030 Reset mid-wait or mid-response SHALL discard the op with no rvalid after release.

Configuration
REQ-031 With APMU_PMC_WAIT_TIMEOUT_EN defined: S_WAIT lasting TIMEOUT_CYCLES cycles without completion SHALL respond rvalid=1, err=1, rdata = counter value, then S_IDLE; without it, waits are unbounded and TIMEOUT_CYCLES is ignored.

Verification
REQ-032 Write 0x1234 to addr 0x8, read addr 0x8 -> rvalid one cycle after each accept, read rdata=0x00001234, err=0.
REQ-033 Write 0xFFFFFFFE to counter 0, WFO, pulse event_i[0] twice -> rvalid on cycle after wrap, rdata=0, ovf_o[0] back to 0.
REQ-034 Write 0xFFFFFFFF to counter 3 then WFP with three events -> rvalid when counter=1, rdata=0x00000001.
REQ-035 Read addr 0x24 with NUM_COUNTERS=8 -> rvalid=1, err=1, rdata=0; write to same address leaves all counters unchanged.
REQ-036 WFO on idle counter, drop op to PMC_IDLE after 5 cycles -> no rvalid, gnt=1 next cycle; with APMU_PMC_WAIT_TIMEOUT_EN and TIMEOUT_CYCLES=16, held op -> err=1 after 16 cycles.
